// File: rtl/nfc_pkg.sv
// nfc_pkg: request word layout, FSM states and packing helper for the NFC dispatcher
package nfc_pkg;
    localparam int REQ_W   = 264;
    localparam int LEN_LSB = 0;
    localparam int LEN_W   = 24;
    localparam int LBA_LSB = 24;
    localparam int LBA_W   = 48;
    localparam int OPC_LSB = 72;
    localparam int OPC_W   = 16;

    typedef enum logic [1:0] {IDLE, SEL, PUSH} state_t;

    function automatic logic [REQ_W-1:0] pack_req(input logic [OPC_W-1:0] opc,
                                                  input logic [LBA_W-1:0] lba,
                                                  input logic [LEN_W-1:0] len);
        logic [REQ_W-1:0] r;
        r = '0;
        r[OPC_LSB +: OPC_W] = opc;
        r[LBA_LSB +: LBA_W] = lba;
        r[LEN_LSB +: LEN_W] = len;
        return r;
    endfunction
endpackage

// File: rtl/nfc_outst_cnt.sv
// nfc_outst_cnt: per-channel outstanding counter, saturating at MAX, sticky underflow flag
module nfc_outst_cnt #(
    parameter int MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] cnt,
    output logic       err
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt + 4'(inc && cnt != 4'(MAX)) - 4'(dec && cnt != 4'd0);
            err <= err | (dec && cnt == 4'd0);
        end
    end
endmodule

// File: rtl/nfc_req_dispatch.sv
// nfc_req_dispatch: routes host commands to NAND channels with per-channel outstanding limits
module nfc_req_dispatch import nfc_pkg::*; #(
    parameter int    CH_NUM    = 4,
    parameter string MODE      = "ADDR",
    parameter int    CH_LSB    = 16,
    parameter int    MAX_OUTST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [15:0]             i_opc,
    input  logic [47:0]             i_lba,
    input  logic [23:0]             i_len,
    output logic [CH_NUM-1:0]       o_req_valid,
    input  logic [CH_NUM-1:0]       i_req_ready,
    output logic [CH_NUM*REQ_W-1:0] o_req_data,
    input  logic [CH_NUM-1:0]       i_cmd_done,
    output logic                    o_done,
    output logic [7:0]              o_outst_total,
    output logic                    o_err
);
    localparam int CW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;

    state_t            st;
    logic [REQ_W-1:0]  req_q;
    logic [CW-1:0]     rr_ptr, ch_q, ch_sel;
    logic [CH_NUM-1:0] inc, err_v;
    logic [3:0]        cnt [CH_NUM];
    logic [7:0]        sum;
    logic              hs, nz_q, pend_q, arm;

    // the latched request word doubles as the LBA source for channel selection
    assign ch_sel = MODE == "RR" ? rr_ptr : CW'(req_q[LBA_LSB+CH_LSB +: CW] % CH_NUM);
    assign hs     = st == PUSH && i_req_ready[ch_q];
    assign inc    = hs ? CH_NUM'(1) << ch_q : '0;
    assign o_err  = |err_v;

    always_comb begin
        sum = '0;
        for (int i = 0; i < CH_NUM; i++) sum = sum + 8'(cnt[i]);
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        nfc_outst_cnt #(.MAX(MAX_OUTST)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc[k]),
            .dec (i_cmd_done[k]),
            .cnt (cnt[k]),
            .err (err_v[k])
        );
        assign o_req_data[k*REQ_W +: REQ_W] = o_req_valid[k] ? req_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            o_ready     <= 1'b0;
            req_q       <= '0;
            rr_ptr      <= '0;
            ch_q        <= '0;
            o_req_valid <= '0;
        end else begin
            case (st)
                IDLE: begin
                    o_ready <= 1'b1;
                    if (i_valid && o_ready) begin
                        req_q   <= pack_req(i_opc, i_lba, i_len);
                        o_ready <= 1'b0;
                        st      <= SEL;
                    end
                end
                SEL: if (cnt[ch_sel] < 4'(MAX_OUTST)) begin
                    ch_q        <= ch_sel;
                    o_req_valid <= CH_NUM'(1) << ch_sel;
                    st          <= PUSH;
                end
                PUSH: if (hs) begin
                    o_req_valid <= '0;
                    o_ready     <= 1'b1;
                    rr_ptr      <= rr_ptr == CW'(CH_NUM-1) ? '0 : rr_ptr + 1'b1;
                    st          <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    // a drain seen outside IDLE is remembered until the FSM gets back to IDLE
    assign arm = (nz_q || pend_q) && o_outst_total == 8'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_outst_total <= '0;
            nz_q          <= 1'b0;
            pend_q        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_outst_total <= sum;
            nz_q          <= o_outst_total != 8'd0;
            pend_q        <= arm && st != IDLE;
            o_done        <= arm && st == IDLE;
        end
    end
endmodule

// File: tb/tb_nfc_req_dispatch.sv
// tb_nfc_req_dispatch: directed checks of the dispatcher in ADDR and RR modes
module tb_nfc_req_dispatch;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic         valid = 0;
  logic [15:0]  opc = 0;
  logic [47:0]  lba = 0;
  logic [23:0]  len = 0;
  logic         ready, done, err;
  logic [3:0]   req_valid, req_ready = 0, cmd_done = 0;
  logic [1055:0] req_data;
  logic [7:0]   total;
  logic         r_valid = 0, r_ready, r_done, r_err;
  logic [3:0]   r_req_valid, r_req_ready = 4'hf, r_cmd_done = 0;
  logic [1055:0] r_req_data;
  logic [7:0]   r_total;
  int acc = 0, ns = 0, np = 0, t0 = -1, t1 = -1;
  logic [3:0] seen [6];
  logic [3:0] exp_rr [6] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2};

  nfc_req_dispatch u_addr (
    .clk(clk), .rst(rst), .i_valid(valid), .o_ready(ready),
    .i_opc(opc), .i_lba(lba), .i_len(len),
    .o_req_valid(req_valid), .i_req_ready(req_ready), .o_req_data(req_data),
    .i_cmd_done(cmd_done), .o_done(done), .o_outst_total(total), .o_err(err)
  );

  nfc_req_dispatch #(.MODE("RR")) u_rr (
    .clk(clk), .rst(rst), .i_valid(r_valid), .o_ready(r_ready),
    .i_opc(opc), .i_lba(lba), .i_len(len),
    .o_req_valid(r_req_valid), .i_req_ready(r_req_ready), .o_req_data(r_req_data),
    .i_cmd_done(r_cmd_done), .o_done(r_done), .o_outst_total(r_total), .o_err(r_err)
  );

  task automatic chk(input string tag, input logic [1055:0] obs, input logic [1055:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick;
  endtask

  task automatic send(input logic [47:0] a, input logic [15:0] o, input logic [23:0] l);
    int n;
    n = 0;
    opc = o; lba = a; len = l; valid = 1;
    while (!ready && n < 50) begin tick; n++; end
    chk("send_ready", ready, 1'b1);
    tick;
    valid = 0;
  endtask

  initial begin
    settle(3);
    chk("rst_ready", ready, 1'b0);
    chk("rst_valid", req_valid, 4'b0000);
    chk("rst_data", req_data, 1056'h0);
    chk("rst_total", total, 8'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 0;
    tick;
    chk("ready_after_rst", ready, 1'b1);
    opc = 16'h1111; lba = 48'h0; len = 24'h10;
    r_valid = 1;
    for (int i = 0; i < 40; i++) begin
      if (r_req_valid != 4'b0000 && ns < 6) begin seen[ns] = r_req_valid; ns++; end
      if (r_valid && r_ready) acc++;
      tick;
      if (acc == 6) r_valid = 0;
    end
    chk("rr_seen", ns, 6);
    for (int k = 0; k < 6; k++) chk("rr_channel", seen[k], exp_rr[k]);
    chk("rr_total", r_total, 8'd6);
    req_ready = 4'b0000;
    send(48'h0000_0002_0000, 16'hA5C3, 24'h001000);
    settle(2);
    chk("a_onehot", req_valid, 4'b0100);
    chk("a_opc", req_data[2*264+72 +: 16], 16'hA5C3);
    chk("a_lba", req_data[2*264+24 +: 48], 48'h0000_0002_0000);
    chk("a_len", req_data[2*264 +: 24], 24'h001000);
    chk("a_hi", req_data[2*264+88 +: 176], 176'h0);
    chk("a_ch0_data", req_data[0 +: 264], 264'h0);
    chk("a_ready_busy", ready, 1'b0);
    req_ready = 4'b0100;
    tick;
    chk("a_hs_valid", req_valid, 4'b0000);
    chk("a_hs_ready", ready, 1'b1);
    chk("a_total_lag", total, 8'd0);
    tick;
    chk("a_total1", total, 8'd1);
    req_ready = 4'hf;
    valid = 1;
    for (int i = 0; i < 7; i++) begin
      if (valid && ready) begin
        if (t0 < 0) t0 = i;
        else if (t1 < 0) t1 = i;
      end
      tick;
    end
    valid = 0;
    chk("accept_latency", t1 - t0, 3);
    settle(5);
    chk("a_total4", total, 8'd4);
    for (int i = 0; i < 12; i++) begin
      cmd_done = i < 4 ? 4'b0100 : 4'b0000;
      if (done) np++;
      tick;
    end
    cmd_done = 0;
    chk("drain_total", total, 8'd0);
    chk("drain_done_once", np, 1);
    chk("drain_err", err, 1'b0);
    cmd_done = 4'b0100;
    tick;
    cmd_done = 0;
    chk("uf_err", err, 1'b1);
    chk("uf_total", total, 8'd0);
    settle(3);
    chk("uf_sticky", err, 1'b1);
    chk("uf_total_hold", total, 8'd0);
    rst = 1;
    tick;
    chk("rst_clears_err", err, 1'b0);
    rst = 0;
    tick;
    req_ready = 4'hf;
    repeat (4) send(48'h0000_0001_0000, 16'h0101, 24'h000200);
    settle(4);
    chk("s_total4", total, 8'd4);
    req_ready = 4'b0000;
    send(48'h0000_0001_0000, 16'h0505, 24'h000200);
    settle(4);
    chk("stall_valid", req_valid, 4'b0000);
    chk("stall_ready", ready, 1'b0);
    chk("stall_total", total, 8'd4);
    cmd_done = 4'b0010;
    tick;
    cmd_done = 0;
    tick;
    chk("unstall_valid", req_valid, 4'b0010);
    chk("unstall_opc", req_data[1*264+72 +: 16], 16'h0505);
    req_ready = 4'hf;
    tick;
    chk("unstall_ready", ready, 1'b1);
    settle(2);
    chk("unstall_total", total, 8'd4);
    cmd_done = 4'b0010;
    tick;
    cmd_done = 0;
    settle(2);
    chk("sim_pre_total", total, 8'd3);
    req_ready = 4'b0000;
    send(48'h0000_0001_0000, 16'h0606, 24'h000300);
    tick;
    chk("sim_valid", req_valid, 4'b0010);
    req_ready = 4'b0010;
    cmd_done = 4'b0010;
    tick;
    req_ready = 4'b0000;
    cmd_done = 0;
    settle(2);
    chk("sim_total", total, 8'd3);
    chk("sim_err", err, 1'b0);
    send(48'h0000_0003_0000, 16'h0707, 24'h000400);
    tick;
    chk("mid_valid", req_valid, 4'b1000);
    rst = 1;
    #1;
    chk("mid_rst_valid", req_valid, 4'b0000);
    chk("mid_rst_data", req_data, 1056'h0);
    chk("mid_rst_total", total, 8'd0);
    chk("mid_rst_ready", ready, 1'b0);
    tick;
    rst = 0;
    req_ready = 4'hf;
    settle(4);
    chk("post_rst_valid", req_valid, 4'b0000);
    chk("post_rst_total", total, 8'd0);
    chk("post_rst_ready", ready, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nfc_req_dispatch.md
NFC_REQ_DISPATCH -- requirements
Module: nfc_req_dispatch

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of NAND channels (1..8).
REQ-002 SHALL have parameter MODE, default "ADDR", channel select policy: "ADDR" (LBA bits) or "RR" (round-robin).
REQ-003 SHALL have parameter CH_LSB, default 16, LSB of the channel field in i_lba when MODE="ADDR".
REQ-004 SHALL have parameter MAX_OUTST, default 4, maximum outstanding requests per channel (1..15).
REQ-005 SHALL have port clk, input, 1, single clock; one clock, all logic synchronous to it.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have ports i_valid (in, 1) and o_ready (out, 1), the host command handshake.
REQ-008 SHALL have ports i_opc (in, 16), i_lba (in, 48) and i_len (in, 24): opcode, logical block address and byte length.
REQ-009 SHALL have ports o_req_valid (out, CH_NUM) and i_req_ready (in, CH_NUM), one request handshake per channel.
REQ-010 SHALL have port o_req_data, out, CH_NUM*264, per-channel request words with channel k at bits [k*264 +: 264].
REQ-011 SHALL have port i_cmd_done, in, CH_NUM, a one-cycle completion pulse per channel.
REQ-012 SHALL have port o_done, out, 1, a one-cycle pulse when all channels become idle.
REQ-013 SHALL have port o_outst_total, out, 8, sum of outstanding requests over all channels.
REQ-014 SHALL have port o_err, out, 1, sticky completion-underflow flag.

Function
REQ-015 SHALL run FSM IDLE -> SEL -> PUSH -> IDLE.
REQ-016 SHALL drive o_ready=1 only in IDLE; on i_valid&o_ready it SHALL latch opc/lba/len and enter SEL.
REQ-017 SEL channel, MODE="ADDR": ch = i_lba[CH_LSB +: clog2(CH_NUM)] mod CH_NUM.
REQ-018 SEL channel, MODE="RR": ch = rr_ptr.
REQ-019 SEL SHALL stay in SEL while outst[ch]==MAX_OUTST, and SHALL enter PUSH the first cycle outst[ch]<MAX_OUTST.
REQ-020 PUSH SHALL hold o_req_valid[ch]=1 with stable data until i_req_ready[ch]; all other o_req_valid bits SHALL be 0.
REQ-021 On the PUSH handshake it SHALL increment outst[ch], advance rr_ptr modulo CH_NUM (wrapping CH_NUM-1 -> 0), and return to IDLE, for 3-cycle minimum accept-to-accept latency.
REQ-022 Request packing SHALL be [263:88]=0, [87:72]=opc, [71:24]=lba, [23:0]=len.
REQ-023 i_cmd_done[k] with outst[k]>0 SHALL decrement outst[k]; simultaneous increment and decrement on the same channel SHALL leave the count unchanged.
REQ-024 i_cmd_done[k] with outst[k]==0 SHALL be ignored and SHALL set o_err until reset.
REQ-025 o_outst_total SHALL be registered, one cycle after the counters change.
REQ-026 o_done SHALL pulse one cycle when o_outst_total transitions from nonzero to zero and FSM is IDLE; if non-IDLE at transition, pulse on return to IDLE if total still zero.

Reset
REQ-027 rst SHALL force FSM=IDLE, rr_ptr=0, all outst=0, o_ready=0 during reset (1 the first cycle after), o_req_valid=0, o_req_data=0, o_done=0, o_outst_total=0 and o_err=0.
REQ-028 Reset mid-PUSH SHALL drop the pending request with no handshake, and the request SHALL NOT be counted.

Structure
REQ-029 Package nfc_pkg SHALL hold REQ_W=264, the field offsets of REQ-022 and the FSM state enum.
REQ-030 One sub-module, nfc_outst_cnt (per-channel saturating up/down counter with underflow flag), SHALL be instantiated CH_NUM times.

Verification
REQ-031 With MODE=ADDR and CH_LSB=16, lba=0x0002_0000 SHALL give o_req_valid=4'b0100 and data[87:72]=i_opc; i_req_ready tied high SHALL give accept-to-accept of 3 cycles.
REQ-032 With MODE=RR, 6 back-to-back commands SHALL hit channels 0,1,2,3,0,1; o_outst_total SHALL read 6.
REQ-033 Five commands to ch1 with MAX_OUTST=4 and no done SHALL stall in SEL; one i_cmd_done[1] SHALL let the fifth issue, and o_outst_total SHALL stay 4.
REQ-034 i_cmd_done[1] in the same cycle as the ch1 PUSH handshake SHALL leave outst[1] unchanged.
REQ-035 i_cmd_done[2] with outst[2]=0 SHALL set o_err=1 with counts unchanged; o_err SHALL clear only on rst.
REQ-036 Draining all outstanding to zero SHALL pulse o_done exactly once; rst asserted during PUSH SHALL give o_req_valid=0 and o_outst_total=0.
